// File: rtl/linemem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the line memory arbiter.
// Handshake: a requester raises req with a stable payload and keeps both
// unchanged until it sees gnt high in the same cycle; gnt is the acceptance
// strobe, and each gnt is answered by exactly one rvalid pulse one cycle later
// (two cycles later for sub-word writes). There is no back-pressure on rvalid.
interface linemem_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    // fetch port (read only)
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    // data port (read/write with byte enables)
    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_be;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    // single-port line memory
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    // arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // requesters plus memory (environment side)
    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/linemem_arbiter.sv
// Arbiter sharing one single-port line memory between a fetch read port and a
// read/write data port. Data port has priority, bounded by a streak counter so
// fetch is served after MAX_STREAK consecutive data grants. Sub-word writes
// are done as read (grant cycle) + merged write (S_RMW cycle).
module linemem_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4,
    localparam int STREAK_W  = $clog2(MAX_STREAK + 1),
    localparam int BE_W      = DATA_W / 8
) (
    input  logic                clk,
    input  logic                rst,
    linemem_arbiter_if.slave    bus,
    output logic [1:0]          dbg_state_o,
    output logic [STREAK_W-1:0] dbg_streak_o
);

    typedef enum logic [1:0] {
        S_ARB = 2'd0,
        S_RMW = 2'd1
    } state_t;

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    // latched sub-word write, consumed in S_RMW
    logic [ADDR_W-1:0]   rmw_addr_q;
    logic [BE_W-1:0]     rmw_be_q;
    logic [DATA_W-1:0]   rmw_wdata_q;

    // memory bus values held across idle cycles
    logic [ADDR_W-1:0]   addr_hold_q;
    logic [DATA_W-1:0]   wdata_hold_q;

    // response pipeline
    logic                if_rvalid_q;
    logic                d_rvalid_q;
    logic                d_is_read_q;

    // grant decision and operation classification
    logic                in_arb;
    logic                fetch_win;
    logic                if_gnt_w;
    logic                d_gnt_w;
    logic                be_full;
    logic                be_zero;
    logic                d_single;
    logic                d_skip;
    logic                d_rmw_start;
    logic                rmw_write;
    logic [DATA_W-1:0]   merged_w;
    logic                mem_en_w;
    logic                mem_we_w;
    logic [ADDR_W-1:0]   mem_addr_w;
    logic [DATA_W-1:0]   mem_wdata_w;

    // Grants are only possible in S_ARB and never while reset is asserted.
    assign in_arb    = (state_q == S_ARB) && !rst;
    assign fetch_win = bus.if_req && (!bus.d_req || (streak_q == STREAK_MAX));
    assign if_gnt_w  = in_arb && fetch_win;
    assign d_gnt_w   = in_arb && bus.d_req && !fetch_win;

    assign be_full     = &bus.d_be;
    assign be_zero     = ~|bus.d_be;
    assign d_single    = d_gnt_w && (!bus.d_we || be_full);
    assign d_skip      = d_gnt_w && bus.d_we && be_zero;
    assign d_rmw_start = d_gnt_w && bus.d_we && !be_full && !be_zero;
    assign rmw_write   = (state_q == S_RMW) && !rst;

    // Byte merge of latched write data over the word read in the grant cycle.
    always_comb begin
        merged_w = bus.mem_rdata;
        for (int i = 0; i < BE_W; i++) begin
            if (rmw_be_q[i]) begin
                merged_w[i*8 +: 8] = rmw_wdata_q[i*8 +: 8];
            end
        end
    end

    // Memory command: driven from the grant decision, held when idle.
    always_comb begin
        mem_en_w    = if_gnt_w || d_single || d_rmw_start || rmw_write;
        mem_we_w    = (d_single && bus.d_we) || rmw_write;
        mem_addr_w  = addr_hold_q;
        mem_wdata_w = wdata_hold_q;
        if (if_gnt_w) begin
            mem_addr_w = bus.if_addr;
        end else if (d_single || d_rmw_start) begin
            mem_addr_w = bus.d_addr;
        end else if (rmw_write) begin
            mem_addr_w = rmw_addr_q;
        end
        if (d_single) begin
            mem_wdata_w = bus.d_wdata;
        end else if (rmw_write) begin
            mem_wdata_w = merged_w;
        end
    end

    // Next state and streak; S_RMW leaves the streak untouched.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        case (state_q)
            S_ARB: begin
                if (d_rmw_start) begin
                    state_d = S_RMW;
                end
                if (!bus.if_req || if_gnt_w) begin
                    streak_d = '0;
                end else if (d_gnt_w && (streak_q != STREAK_MAX)) begin
                    streak_d = streak_q + 1'b1;
                end
            end
            S_RMW: begin
                state_d = S_ARB;
            end
            default: begin
                state_d  = S_ARB;
                streak_d = '0;
            end
        endcase
    end

    // FSM, latches, bus hold registers and registered response strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_ARB;
            streak_q     <= '0;
            rmw_addr_q   <= '0;
            rmw_be_q     <= '0;
            rmw_wdata_q  <= '0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            d_is_read_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            if (d_rmw_start) begin
                rmw_addr_q  <= bus.d_addr;
                rmw_be_q    <= bus.d_be;
                rmw_wdata_q <= bus.d_wdata;
            end
            if (mem_en_w) begin
                addr_hold_q <= mem_addr_w;
            end
            if (d_single || rmw_write) begin
                wdata_hold_q <= mem_wdata_w;
            end
            if_rvalid_q <= if_gnt_w;
            d_rvalid_q  <= d_single || d_skip || rmw_write;
            d_is_read_q <= d_single && !bus.d_we;
        end
    end

    assign bus.if_gnt    = if_gnt_w;
    assign bus.d_gnt     = d_gnt_w;
    assign bus.mem_en    = mem_en_w;
    assign bus.mem_we    = mem_we_w;
    assign bus.mem_addr  = mem_addr_w;
    assign bus.mem_wdata = mem_wdata_w;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rvalid_q ? bus.mem_rdata : '0;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = (d_rvalid_q && d_is_read_q) ? bus.mem_rdata : '0;

    assign dbg_state_o  = state_q;
    assign dbg_streak_o = streak_q;

endmodule

// File: tb/tb_linemem_arbiter.sv
// Directed bench for linemem_arbiter: a vector table for the single-cycle and
// partial-write flows, plus hand sequences for reset, starvation guard and
// reset in the middle of a read-modify-write.
module tb_linemem_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  dbg_state;
    logic [2:0]  dbg_streak;

    int total;
    int bad;

    linemem_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus ();

    linemem_arbiter #(.ADDR_W(14), .DATA_W(32), .MAX_STREAK(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .dbg_state_o  (dbg_state),
        .dbg_streak_o (dbg_streak)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // line memory model with a backdoor preload port
    logic [31:0] mem [0:16383];
    logic [31:0] mem_rdata_q;
    logic        pre_we;
    logic [13:0] pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            mem_rdata_q <= mem[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = mem_rdata_q;

    typedef struct {
        logic        ireq;
        logic [13:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [13:0] daddr;
        logic [31:0] dwdata;
        logic        g_i;
        logic        g_d;
        logic        en;
        logic        we;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic        irv;
        logic [31:0] ird;
        logic        drv;
        logic [31:0] drd;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mkv(
        input logic ireq, input logic [13:0] iaddr, input logic dreq, input logic dwe,
        input logic [3:0] dbe, input logic [13:0] daddr, input logic [31:0] dwdata,
        input logic g_i, input logic g_d, input logic en, input logic we,
        input logic [13:0] addr, input logic [31:0] wdata,
        input logic irv, input logic [31:0] ird, input logic drv, input logic [31:0] drd);
        vec_t v;
        v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe; v.dbe = dbe;
        v.daddr = daddr; v.dwdata = dwdata; v.g_i = g_i; v.g_d = g_d; v.en = en;
        v.we = we; v.addr = addr; v.wdata = wdata; v.irv = irv; v.ird = ird;
        v.drv = drv; v.drd = drd;
        return v;
    endfunction

    // scoreboard compare
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic ireq, input logic [13:0] iaddr, input logic dreq,
                         input logic dwe, input logic [3:0] dbe, input logic [13:0] daddr,
                         input logic [31:0] dwdata);
        bus.if_req  = ireq;
        bus.if_addr = iaddr;
        bus.d_req   = dreq;
        bus.d_we    = dwe;
        bus.d_be    = dbe;
        bus.d_addr  = daddr;
        bus.d_wdata = dwdata;
    endtask

    task automatic idle();
        drive(1'b0, 14'h0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    endtask

    task automatic preload(input logic [13:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        rst = 1'b1;
        // requests asserted during reset must not produce grants
        drive(1'b1, 14'h0010, 1'b1, 1'b1, 4'hF, 14'h0020, 32'h12345678);

        // reset block: every output low while rst is high
        @(negedge clk);
        #1;
        chk("rst if_gnt",    32'(bus.if_gnt),    32'h0);
        chk("rst d_gnt",     32'(bus.d_gnt),     32'h0);
        chk("rst mem_en",    32'(bus.mem_en),    32'h0);
        chk("rst mem_we",    32'(bus.mem_we),    32'h0);
        chk("rst mem_addr",  32'(bus.mem_addr),  32'h0);
        chk("rst mem_wdata", bus.mem_wdata,      32'h0);
        chk("rst if_rvalid", 32'(bus.if_rvalid), 32'h0);
        chk("rst if_rdata",  bus.if_rdata,       32'h0);
        chk("rst d_rvalid",  32'(bus.d_rvalid),  32'h0);
        chk("rst d_rdata",   bus.d_rdata,        32'h0);
        chk("rst state",     32'(dbg_state),     32'h0);
        chk("rst streak",    32'(dbg_streak),    32'h0);
        idle();

        preload(14'h0010, 32'h11223344);
        preload(14'h2005, 32'hAABBCCDD);
        preload(14'h0100, 32'h55667788);
        @(negedge clk);
        rst = 1'b0;

        // ireq iaddr dreq dwe dbe daddr dwdata | gi gd en we addr wdata | irv ird drv drd
        tbl[0]  = mkv(1, 14'h0010, 0, 0, 4'h0, 14'h0,    32'h0,        1, 0, 1, 0, 14'h0010, 32'h0,        0, 32'h0,        0, 32'h0);
        tbl[1]  = mkv(0, 14'h0,    0, 0, 4'h0, 14'h0,    32'h0,        0, 0, 0, 0, 14'h0010, 32'h0,        1, 32'h11223344, 0, 32'h0);
        tbl[2]  = mkv(0, 14'h0,    1, 1, 4'h5, 14'h2005, 32'h11223344, 0, 1, 1, 0, 14'h2005, 32'h0,        0, 32'h0,        0, 32'h0);
        tbl[3]  = mkv(0, 14'h0,    0, 0, 4'h0, 14'h0,    32'h0,        0, 0, 1, 1, 14'h2005, 32'hAA22CC44, 0, 32'h0,        0, 32'h0);
        tbl[4]  = mkv(0, 14'h0,    0, 0, 4'h0, 14'h0,    32'h0,        0, 0, 0, 0, 14'h2005, 32'hAA22CC44, 0, 32'h0,        1, 32'h0);
        tbl[5]  = mkv(0, 14'h0,    1, 0, 4'hF, 14'h2005, 32'h0,        0, 1, 1, 0, 14'h2005, 32'h0,        0, 32'h0,        0, 32'h0);
        tbl[6]  = mkv(0, 14'h0,    0, 0, 4'h0, 14'h0,    32'h0,        0, 0, 0, 0, 14'h2005, 32'h0,        0, 32'h0,        1, 32'hAA22CC44);
        tbl[7]  = mkv(0, 14'h0,    1, 1, 4'h0, 14'h0100, 32'hDEADBEEF, 0, 1, 0, 0, 14'h2005, 32'h0,        0, 32'h0,        0, 32'h0);
        tbl[8]  = mkv(0, 14'h0,    1, 0, 4'hF, 14'h0100, 32'h0,        0, 1, 1, 0, 14'h0100, 32'h0,        0, 32'h0,        1, 32'h0);
        tbl[9]  = mkv(0, 14'h0,    0, 0, 4'h0, 14'h0,    32'h0,        0, 0, 0, 0, 14'h0100, 32'h0,        0, 32'h0,        1, 32'h55667788);
        tbl[10] = mkv(0, 14'h0,    1, 1, 4'hF, 14'h3FFF, 32'hFFFFFFFF, 0, 1, 1, 1, 14'h3FFF, 32'hFFFFFFFF, 0, 32'h0,        0, 32'h0);
        tbl[11] = mkv(0, 14'h0,    1, 0, 4'hF, 14'h3FFF, 32'h0,        0, 1, 1, 0, 14'h3FFF, 32'h0,        0, 32'h0,        1, 32'h0);
        tbl[12] = mkv(0, 14'h0,    0, 0, 4'h0, 14'h0,    32'h0,        0, 0, 0, 0, 14'h3FFF, 32'h0,        0, 32'h0,        1, 32'hFFFFFFFF);
        tbl[13] = mkv(0, 14'h0,    1, 1, 4'h3, 14'h0010, 32'h0000ABCD, 0, 1, 1, 0, 14'h0010, 32'h0,        0, 32'h0,        0, 32'h0);
        tbl[14] = mkv(1, 14'h2005, 0, 0, 4'h0, 14'h0,    32'h0,        0, 0, 1, 1, 14'h0010, 32'h1122ABCD, 0, 32'h0,        0, 32'h0);
        tbl[15] = mkv(1, 14'h2005, 0, 0, 4'h0, 14'h0,    32'h0,        1, 0, 1, 0, 14'h2005, 32'h1122ABCD, 0, 32'h0,        1, 32'h0);
        tbl[16] = mkv(0, 14'h0,    0, 0, 4'h0, 14'h0,    32'h0,        0, 0, 0, 0, 14'h2005, 32'h1122ABCD, 1, 32'hAA22CC44, 0, 32'h0);
        tbl[17] = mkv(1, 14'h0010, 0, 0, 4'h0, 14'h0,    32'h0,        1, 0, 1, 0, 14'h0010, 32'h1122ABCD, 0, 32'h0,        0, 32'h0);
        tbl[18] = mkv(0, 14'h0,    0, 0, 4'h0, 14'h0,    32'h0,        0, 0, 0, 0, 14'h0010, 32'h1122ABCD, 1, 32'h1122ABCD, 0, 32'h0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(tbl[i].ireq, tbl[i].iaddr, tbl[i].dreq, tbl[i].dwe, tbl[i].dbe,
                  tbl[i].daddr, tbl[i].dwdata);
            #1;
            chk($sformatf("v%0d if_gnt", i),    32'(bus.if_gnt),    32'(tbl[i].g_i));
            chk($sformatf("v%0d d_gnt", i),     32'(bus.d_gnt),     32'(tbl[i].g_d));
            chk($sformatf("v%0d mem_en", i),    32'(bus.mem_en),    32'(tbl[i].en));
            chk($sformatf("v%0d mem_we", i),    32'(bus.mem_we),    32'(tbl[i].we));
            chk($sformatf("v%0d mem_addr", i),  32'(bus.mem_addr),  32'(tbl[i].addr));
            chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata,      tbl[i].wdata);
            chk($sformatf("v%0d if_rvalid", i), 32'(bus.if_rvalid), 32'(tbl[i].irv));
            chk($sformatf("v%0d if_rdata", i),  bus.if_rdata,       tbl[i].ird);
            chk($sformatf("v%0d d_rvalid", i),  32'(bus.d_rvalid),  32'(tbl[i].drv));
            chk($sformatf("v%0d d_rdata", i),   bus.d_rdata,        tbl[i].drd);
        end
        chk("be0 memory untouched", mem[14'h0100], 32'h55667788);

        // starvation guard: both held, pattern D,D,D,D,F repeating
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, 14'h0010, 1'b1, 1'b0, 4'hF, 14'h0100, 32'h0);
            #1;
            chk($sformatf("s%0d if_gnt", i), 32'(bus.if_gnt), 32'((i % 5) == 4));
            chk($sformatf("s%0d d_gnt", i),  32'(bus.d_gnt),  32'((i % 5) != 4));
            chk($sformatf("s%0d if_rvalid", i), 32'(bus.if_rvalid), 32'(i > 0 && ((i - 1) % 5) == 4));
            chk($sformatf("s%0d d_rvalid", i),  32'(bus.d_rvalid),  32'(i > 0 && ((i - 1) % 5) != 4));
            chk($sformatf("s%0d d_rdata", i), bus.d_rdata,
                (i > 0 && ((i - 1) % 5) != 4) ? 32'h55667788 : 32'h0);
            chk($sformatf("s%0d if_rdata", i), bus.if_rdata,
                (i > 0 && ((i - 1) % 5) == 4) ? 32'h1122ABCD : 32'h0);
        end
        @(negedge clk);
        idle();
        #1;
        chk("s_end if_rvalid", 32'(bus.if_rvalid), 32'h1);
        chk("s_end d_rvalid",  32'(bus.d_rvalid),  32'h0);

        // reset in the middle of a partial write
        @(negedge clk);
        drive(1'b1, 14'h0010, 1'b1, 1'b1, 4'h1, 14'h0100, 32'h000000EE);
        #1;
        chk("rr grant d_gnt",  32'(bus.d_gnt),  32'h1);
        chk("rr grant if_gnt", 32'(bus.if_gnt), 32'h0);
        @(negedge clk);
        drive(1'b1, 14'h0010, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
        #1;
        chk("rr state rmw",  32'(dbg_state),  32'h1);
        chk("rr streak",     32'(dbg_streak), 32'h1);
        chk("rr mem_we pre", 32'(bus.mem_we), 32'h1);
        chk("rr if_gnt",     32'(bus.if_gnt), 32'h0);
        #1;
        rst = 1'b1;
        idle();
        #1;
        chk("rr mem_en",  32'(bus.mem_en),  32'h0);
        chk("rr mem_we",  32'(bus.mem_we),  32'h0);
        chk("rr state",   32'(dbg_state),   32'h0);
        chk("rr streak0", 32'(dbg_streak),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rr d_rvalid a", 32'(bus.d_rvalid), 32'h0);
        chk("rr mem kept",   mem[14'h0100],     32'h55667788);
        @(negedge clk);
        drive(1'b0, 14'h0, 1'b1, 1'b0, 4'hF, 14'h0100, 32'h0);
        #1;
        chk("rr d_rvalid b", 32'(bus.d_rvalid), 32'h0);
        chk("rr read gnt",   32'(bus.d_gnt),    32'h1);
        @(negedge clk);
        idle();
        #1;
        chk("rr readback rvalid", 32'(bus.d_rvalid), 32'h1);
        chk("rr readback data",   bus.d_rdata,       32'h55667788);

        // final report
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/linemem_arbiter.md
# linemem_arbiter

Shares the single-port, 16K x 32-bit line memory between two requesters: a read-only fetch port and a read/write data port with byte enables. Issues at most one memory operation per cycle and returns read data one cycle after each grant. Sub-word writes use an internal read-modify-write sequence, because the memory has only a global write enable. Sits between the core's fetch/load-store units and the line memory; bank selection via `mem_addr[13]` happens downstream.

## Interface
- `ADDR_W`, 14, word address width.
- `DATA_W`, 32, data width; the byte-enable width is `DATA_W/8`.
- `MAX_STREAK`, 4, maximum consecutive data-port grants while fetch is waiting.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch read request.
- `if_addr` in ADDR_W: fetch word address.
- `if_gnt` out 1: fetch request accepted this cycle (combinational).
- `if_rvalid` out 1: fetch read data valid.
- `if_rdata` out DATA_W: fetch read data.
- `d_req` in 1: data-port request.
- `d_we` in 1: 1 = write, 0 = read.
- `d_be` in DATA_W/8: byte enables (writes only).
- `d_addr` in ADDR_W: data-port word address.
- `d_wdata` in DATA_W: write data.
- `d_gnt` out 1: data request accepted this cycle (combinational).
- `d_rvalid` out 1: read data valid, or write done.
- `d_rdata` out DATA_W: data-port read data.
- `mem_en` out 1: memory enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid the cycle after a read is issued.

## Operation
- **Request rules.** A requester holds `req` and its payload stable until `gnt`. It may present a new request in the cycle after `gnt`. Back-to-back grants are legal.
- **State `S_ARB`:**
  - Each cycle, grant at most one requester. The data port wins by default.
  - Exception: fetch wins when `if_req` = 1 and `streak` = `MAX_STREAK`.
- **`streak` counter:**
  - Increments on each data grant while `if_req` = 1.
  - Clears on any fetch grant, or whenever `if_req` = 0.
  - Saturates at `MAX_STREAK`.
- **Fetch grant:** `mem_en`=1, `mem_we`=0, `mem_addr`=`if_addr`.
- **Data read, or write with `d_be` = all-ones:** a single memory access with `mem_we`=`d_we` and `mem_wdata`=`d_wdata`.
- **Data write with `d_be` = 0:** granted, but no memory access (`mem_en`=0). Acknowledged normally.
- **Data write with a partial `d_be`:**
  - Grant cycle: issue a memory read of `d_addr`.
  - Latch address, `d_be` and `d_wdata`; go to `S_RMW`.
- **State `S_RMW`:**
  - No grants in this cycle.
  - Write the merged word to the latched address, then return to `S_ARB`.
  - Merged byte i = `be[i]` ? `wdata` byte i : `mem_rdata` byte i.
  - `streak` is unchanged by the `S_RMW` cycle.
- **Idle cycles:** `mem_en`=0, and `mem_addr`/`mem_wdata` hold their previous values.
- **Read data:** `if_rdata` = `mem_rdata` when `if_rvalid` = 1, else 0. `d_rdata` = `mem_rdata` when `d_rvalid` = 1 and the operation was a read, else 0.
- **Address range:** out-of-range addresses do not exist (the full 2^ADDR_W space is valid). Address wrap is the caller's concern.

## Timing
- **Reset values:** state `S_ARB`, `streak` 0, every output 0. `if_gnt`/`d_gnt` are also forced to 0 while `rst` = 1.
- **Reset during `S_RMW`:** the merge write is abandoned (no memory write), and no `d_rvalid` is issued.
- **Fetch read:** grant in cycle N; `if_rvalid` = 1 in cycle N+1 only.
- **Single-cycle data operation** (read, full write, or `d_be`=0 write): `d_rvalid` = 1 in cycle N+1.
- **Partial write:** grant in N, read in N, write in N+1, `d_rvalid` = 1 in N+2.
  - Because no grant occurs in N+1, a request pending in N+1 is granted in N+2 at the earliest.
- **Pipelining:** maximum throughput is one grant per cycle. `rvalid` pulses are therefore never stretched; each grant yields exactly one pulse.
- **Both requests present in the same cycle:** exactly one `gnt`. The loser waits with `gnt` = 0 and gets no `rvalid`.
- **`mem_en` / `mem_we` / `mem_addr` / `mem_wdata`** are combinational from the grant decision and state, and are valid in the grant (or `S_RMW`) cycle.

## Test plan
- **Reset and read:** reset, then preload 0x0010=0x11223344; fetch read 0x0010 -> `if_gnt` in cycle 0, `if_rvalid` with `if_rdata` = 0x11223344 in cycle 1. All outputs are 0 during reset.
- **Partial write:** word 0x2005=0xAABBCCDD; data write `d_be`=4'b0101, `d_wdata`=0x11223344 -> `mem_we` in cycle 1 with `mem_wdata`=0xAA22CC44; `d_rvalid` in cycle 2; a following read returns 0xAA22CC44.
- **Starvation guard:** `d_req` and `if_req` held continuously -> grant pattern D,D,D,D,F repeating (`MAX_STREAK`=4); the fetch grant occurs in cycle 4.
- **Write edge cases:** write with `d_be`=0 -> `d_gnt`, `mem_en` stays 0, `d_rvalid` next cycle, memory unchanged. Full write 0xFFFFFFFF to 0x3FFF -> single-cycle write, readback matches.
- **Reset during RMW:** assert `rst` in the `S_RMW` cycle -> no memory write occurs, no `d_rvalid`, and the arbiter resumes in `S_ARB` with `streak` 0.
- **Fetch during RMW:** fetch request arrives during a partial write -> `if_gnt` in the cycle after `S_RMW` (cycle 2), `if_rvalid` in cycle 3.
